// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared state encoding and default width for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : One-bit combinational full subtractor cell (a - b - bin).
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial N-bit unsigned subtractor D = A - B, LSB first,
//               with borrow-out and start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         busy,
    output logic         done
);

    localparam int             CW     = $clog2(N);
    localparam logic [CW-1:0]  c_last = CW'(N - 1);

    state_t          r_state;
    logic [N-1:0]    r_ra;
    logic [N-1:0]    r_rb;
    logic [N-1:0]    r_rd;
    logic [N-1:0]    r_d;
    logic            r_bout;
    logic            r_borrow;
    logic [CW-1:0]   r_cnt;

    logic            w_d;
    logic            w_bout;
    logic [N-1:0]    w_rd_next;

    full_subtractor u_cell (
        .a    (r_ra[0]),
        .b    (r_rb[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // Result bits enter at the MSB so that after N shifts bit 0 sits at the LSB.
    assign w_rd_next = {w_d, r_rd[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ra     <= '0;
            r_rb     <= '0;
            r_rd     <= '0;
            r_d      <= '0;
            r_bout   <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ra     <= A;
                        r_rb     <= B;
                        r_rd     <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_ra     <= r_ra >> 1;
                    r_rb     <= r_rb >> 1;
                    r_rd     <= w_rd_next;
                    r_borrow <= w_bout;
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_d     <= w_rd_next;
                        r_bout  <= w_bout;
                        r_state <= DONE;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign D    = r_d;
    assign Bout = r_bout;
    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);

endmodule : serial_subtractor
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit unsigned subtractor computing D = A − B with a borrow-out, one bit per clock, LSB first. It is the inverse-operation companion to the team's combinational adder blocks in the Digital Design lab set. It replaces a wide combinational datapath with a single full-subtractor cell, a borrow flip-flop and shift registers, and uses a start/busy/done handshake.

## Interface
Parameters:
- N, default 8: operand and result width in bits; legal range is N ≥ 2.

Ports (name, direction, width, meaning):
- clk: input, 1. Single clock; all state updates on the rising edge.
- rst: input, 1. Reset, synchronous, active-high.
- start: input, 1. Request a subtraction. Sampled only in IDLE.
- A: input, N. Minuend. Captured on the accepted-start edge.
- B: input, N. Subtrahend. Captured on the accepted-start edge.
- D: output, N. Difference (A − B) mod 2^N. Registered.
- Bout: output, 1. Final borrow: 1 exactly when A < B unsigned. Registered.
- busy: output, 1. High while bits are being processed.
- done: output, 1. One-cycle pulse when D and Bout are updated.

## Operation
- FSM states and transitions:
  - IDLE → SHIFT when start = 1.
  - SHIFT → SHIFT while the counter is below N−1.
  - SHIFT → DONE on the cycle that processes bit N−1.
  - DONE → IDLE unconditionally.
- On accepted start:
  - ra ← A and rb ← B.
  - borrow ← 0, cnt ← 0.
  - Result shift register rd ← 0.
- Each SHIFT cycle, using the bit cell:
  - d = ra[0] ^ rb[0] ^ borrow.
  - bnext = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & borrow).
  - ra and rb shift right by one.
  - rd shifts right with d entering at bit N−1.
  - borrow ← bnext, cnt ← cnt + 1.
- Entering DONE:
  - D ← the final rd, including the last bit.
  - Bout ← the final borrow.
- D and Bout hold their values until the next completion. Inputs A and B may change freely after the start edge.
- start is ignored in SHIFT and DONE; there is no queueing.
- Counter width is $clog2(N). It never wraps within an operation.
- Reset (any state, including mid-operation):
  - State → IDLE.
  - D = 0, Bout = 0, busy = 0, done = 0.
  - ra, rb, rd, borrow and cnt all cleared.
  - The partial result is discarded.
- Reset has priority over start when both are high on the same edge.

## Timing
- Let start be sampled high in IDLE at edge k.
- busy = 1 from after edge k through edge k+N (exactly N cycles).
- done = 1 for exactly one cycle, after edge k+N. D and Bout show the new values in that same cycle.
- busy = 0 while done = 1.
- Next start is accepted at edge k+N+2 at the earliest, when the FSM is back in IDLE. Throughput is one operation per N+2 cycles.
- busy and done are decoded directly from state registers (Moore outputs), with no combinational path from start.

## Structure
- Shared package serial_pkg holds:
  - State typedef: enum logic [1:0] {IDLE, SHIFT, DONE}.
  - Constant DEFAULT_WIDTH = 8.
- Sub-module full_subtractor is purely combinational:
  - Inputs a, b, bin; outputs d and bout.
  - Instantiated once in the datapath.
  - Unit-testable exhaustively over its 8 input combinations.
- The top level contains the FSM, counter, operand/result shift registers, borrow register and output registers.

## Test plan
- Reset, then idle 5 cycles: D = 0x00, Bout = 0, busy = 0, done = 0 throughout.
- N = 8, A = 0x5A, B = 0x23, start pulsed one cycle:
  - busy high for 8 cycles.
  - done pulses at k+9.
  - D = 0x37, Bout = 0.
- A = 0x10, B = 0x20 → D = 0xF0, Bout = 1. Then A = 0x00, B = 0x01 → D = 0xFF, Bout = 1. Then A = 0xFF, B = 0xFF → D = 0x00, Bout = 0.
- Start A = 0x80, B = 0x01, and re-assert start with A = 0x00, B = 0xFF at cycles k+3 and k+9 (during DONE):
  - Single result D = 0x7F, Bout = 0.
  - Only one done pulse.
- Start A = 0xC3, B = 0x3C, then assert rst at k+4:
  - Next cycle: state IDLE, busy = 0, D = 0x00, Bout = 0.
  - No done pulse.
  - A fresh start then completes normally with D = 0x87.
- Randomized sweep of 500 pairs, checked against a (A − B) mod 256 reference model with Bout = (A < B):
  - Every result must match.
  - Each must finish in exactly N+1 cycles from start.
